// File: rtl/spike_feeder_if.sv
// Host sample stream, network handshake and window-count result bundle for spike_feeder.
// master = host/network environment, slave = the feeder.
interface spike_feeder_if #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 2,
  parameter int unsigned CNT_W = 8
);
  logic                   s_valid;
  logic                   s_ready;
  logic [N_IN-1:0]        s_data;
  logic                   s_last;
  logic                   net_ready;
  logic                   net_sample;
  logic [N_OUT-1:0]       net_out_spikes;
  logic                   net_start;
  logic                   net_sample_ready;
  logic [N_IN-1:0]        net_in_spikes;
  logic                   res_valid;
  logic [N_OUT*CNT_W-1:0] res_count;
  logic                   busy;

  modport master (
    output s_valid, s_data, s_last, net_ready, net_sample, net_out_spikes,
    input  s_ready, net_start, net_sample_ready, net_in_spikes, res_valid, res_count, busy
  );

  modport slave (
    input  s_valid, s_data, s_last, net_ready, net_sample, net_out_spikes,
    output s_ready, net_start, net_sample_ready, net_in_spikes, res_valid, res_count, busy
  );
endinterface

// File: rtl/spike_feeder.sv
// Buffers host spike samples in a FIFO and feeds them to a spiking network one per sample event.
// Define SPIKE_FEEDER_COUNT_EN to add per-output spike counting over each sample window.
module spike_feeder #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 2,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  spike_feeder_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e          r_state;
  logic            r_start;
  logic            r_busy;
  logic            r_ready_en;
  logic            r_sample_q;
  logic            r_pop_pend;
  logic [AW:0]     r_wptr;
  logic [AW:0]     r_rptr;
  logic [N_IN-1:0] r_hold;
  logic [N_IN-1:0] r_mem_data [DEPTH];
  logic [DEPTH-1:0] r_mem_last;

  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic            w_event;
  logic [N_IN-1:0] w_head;
  logic            w_head_last;

  assign w_empty     = (r_wptr == r_rptr);
  assign w_full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_event     = bus.net_sample && !r_sample_q;
  assign w_push      = bus.s_valid && bus.s_ready;
  // A pending pop is only armed with a non-empty FIFO and nothing else pops in between.
  assign w_pop       = r_pop_pend;
  assign w_head      = r_mem_data[r_rptr[AW-1:0]];
  assign w_head_last = r_mem_last[r_rptr[AW-1:0]];

  assign bus.s_ready          = r_ready_en && !w_full;
  assign bus.net_sample_ready = !w_empty && (r_state == StRun);
  assign bus.net_in_spikes    = w_empty ? r_hold : w_head;
  assign bus.net_start        = r_start;
  assign bus.busy             = r_busy;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wptr[AW-1:0]] <= bus.s_data;
      r_mem_last[r_wptr[AW-1:0]] <= bus.s_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_hold     <= '0;
      r_ready_en <= 1'b0;
      r_sample_q <= 1'b0;
      r_pop_pend <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      r_sample_q <= bus.net_sample;
      r_pop_pend <= w_event && (r_state == StRun) && !w_empty;
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop) begin
        r_rptr <= r_rptr + (AW+1)'(1);
        r_hold <= w_head;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.net_ready && !w_empty) begin
            r_state <= StRun;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        StRun: begin
          if (w_pop && w_head_last) r_state <= StDrain;
        end
        StDrain: begin
          // The event after the last sample closes the final window.
          if (w_event) begin
            r_state <= StDone;
            r_start <= 1'b0;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_start <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPIKE_FEEDER_COUNT_EN
  logic                   w_active;
  logic [CNT_W-1:0]       r_cnt [N_OUT];
  logic [CNT_W-1:0]       w_cnt_nxt [N_OUT];
  logic [N_OUT*CNT_W-1:0] r_res_count;
  logic                   r_res_valid;

  assign w_active = (r_state == StRun) || (r_state == StDrain);

  always_comb begin
    for (int unsigned i = 0; i < N_OUT; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (w_active && bus.net_out_spikes[i] && (r_cnt[i] != {CNT_W{1'b1}})) begin
        w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_OUT; i++) r_cnt[i] <= '0;
      r_res_count <= '0;
      r_res_valid <= 1'b0;
    end else begin
      r_res_valid <= w_active && w_event;
      for (int unsigned i = 0; i < N_OUT; i++) begin
        if (w_active && w_event) begin
          r_res_count[i*CNT_W +: CNT_W] <= w_cnt_nxt[i];
          r_cnt[i]                      <= CNT_W'(bus.net_out_spikes[i]);
        end else begin
          r_cnt[i] <= w_cnt_nxt[i];
        end
      end
    end
  end

  assign bus.res_valid = r_res_valid;
  assign bus.res_count = r_res_count;
`else
  logic w_unused_spikes;
  assign w_unused_spikes = ^bus.net_out_spikes;
  assign bus.res_valid   = 1'b0;
  assign bus.res_count   = '0;
`endif
endmodule

// File: tb/tb_spike_feeder.sv
// Self-checking bench for spike_feeder: table vectors, directed corner sequences and random
// stimulus, all compared against a queue-based reference model.
module tb_spike_feeder;
  localparam int unsigned N_IN  = 4;
  localparam int unsigned N_OUT = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 8;
  localparam int MaxCnt = (1 << CNT_W) - 1;
  localparam int MIdle = 0, MRun = 1, MDrain = 2, MDone = 3;
`ifdef SPIKE_FEEDER_COUNT_EN
  localparam bit CountEn = 1'b1;
`else
  localparam bit CountEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spike_feeder_if #(.N_IN(N_IN), .N_OUT(N_OUT), .CNT_W(CNT_W)) bus ();

  spike_feeder #(.N_IN(N_IN), .N_OUT(N_OUT), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model
  typedef struct {logic [N_IN-1:0] data; logic last;} ent_t;
  ent_t            m_q[$];
  int              m_st;
  bit              m_prev, m_pend, m_ready_en, m_res_valid;
  logic [N_IN-1:0] m_hold;
  int              m_cnt [N_OUT];
  int              m_res [N_OUT];

  task automatic model_reset();
    m_q.delete();
    m_st = MIdle; m_prev = 0; m_pend = 0; m_ready_en = 0; m_res_valid = 0; m_hold = '0;
    for (int i = 0; i < N_OUT; i++) begin m_cnt[i] = 0; m_res[i] = 0; end
  endtask

  task automatic model_step();
    bit ev, push, pop, was_empty, head_last;
    int old_st;
    ev        = bus.net_sample && !m_prev;
    was_empty = (m_q.size() == 0);
    push      = bus.s_valid && m_ready_en && (m_q.size() < DEPTH);
    pop       = m_pend;
    head_last = pop ? m_q[0].last : 1'b0;
    old_st    = m_st;
    m_res_valid = 0;
    if (CountEn && (old_st == MRun || old_st == MDrain)) begin
      for (int i = 0; i < N_OUT; i++) begin
        m_cnt[i] = m_cnt[i] + int'(bus.net_out_spikes[i]);
        if (m_cnt[i] > MaxCnt) m_cnt[i] = MaxCnt;
        if (ev) begin m_res[i] = m_cnt[i]; m_cnt[i] = int'(bus.net_out_spikes[i]); end
      end
      m_res_valid = ev;
    end
    case (old_st)
      MIdle:   if (bus.net_ready && !was_empty) m_st = MRun;
      MRun:    if (pop && head_last) m_st = MDrain;
      MDrain:  if (ev) m_st = MDone;
      default: m_st = MIdle;
    endcase
    m_pend = ev && (old_st == MRun) && !was_empty;
    if (pop) begin m_hold = m_q[0].data; void'(m_q.pop_front()); end
    if (push) m_q.push_back('{bus.s_data, bus.s_last});
    m_prev = bus.net_sample;
    m_ready_en = 1;
  endtask

  task automatic compare_model();
    logic [N_OUT*CNT_W-1:0] rc;
    for (int i = 0; i < N_OUT; i++) rc[i*CNT_W +: CNT_W] = CNT_W'(m_res[i]);
    chk("s_ready", bus.s_ready, m_ready_en && (m_q.size() < DEPTH));
    chk("net_sample_ready", bus.net_sample_ready, (m_q.size() > 0) && (m_st == MRun));
    chk("net_in_spikes", bus.net_in_spikes, (m_q.size() > 0) ? m_q[0].data : m_hold);
    chk("net_start", bus.net_start, (m_st == MRun) || (m_st == MDrain));
    chk("busy", bus.busy, m_st != MIdle);
    chk("res_valid", bus.res_valid, m_res_valid);
    chk("res_count", bus.res_count, rc);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic set_idle();
    bus.s_valid = 0; bus.s_data = '0; bus.s_last = 0;
    bus.net_ready = 0; bus.net_sample = 0; bus.net_out_spikes = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_net_start"}, bus.net_start, 0);
    chk({tag, "_net_sample_ready"}, bus.net_sample_ready, 0);
    chk({tag, "_net_in_spikes"}, bus.net_in_spikes, 0);
    chk({tag, "_res_valid"}, bus.res_valid, 0);
    chk({tag, "_res_count"}, bus.res_count, 0);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    set_idle();
    model_reset();
    @(posedge clk); #1;
    check_reset_outputs("rst");
    @(posedge clk); #1;
    rst_n = 1;
    cycle();
    chk("s_ready_after_reset", bus.s_ready, 1);
  endtask

  task automatic pulse_sample();
    bus.net_sample = 1; cycle();
    bus.net_sample = 0; cycle();
  endtask

  typedef struct {
    logic sv; logic [N_IN-1:0] sd; logic sl; logic nr; logic ns;
    logic e_sready; logic e_start; logic e_nsr; logic [N_IN-1:0] e_nis; logic e_busy;
  } vec_t;
  vec_t tbl[16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //           sv sd    sl nr ns   srdy start nsr nis   busy
    tbl[0]  = '{1, 4'hF, 0, 0, 0,   1,   0,    0,  4'hF, 0};
    tbl[1]  = '{1, 4'hE, 0, 0, 0,   1,   0,    0,  4'hF, 0};
    tbl[2]  = '{1, 4'hD, 0, 0, 0,   1,   0,    0,  4'hF, 0};
    tbl[3]  = '{1, 4'hC, 1, 0, 0,   0,   0,    0,  4'hF, 0};
    tbl[4]  = '{0, 4'h0, 0, 1, 0,   0,   1,    1,  4'hF, 1};
    tbl[5]  = '{0, 4'h0, 0, 1, 1,   0,   1,    1,  4'hF, 1};
    tbl[6]  = '{0, 4'h0, 0, 1, 1,   1,   1,    1,  4'hE, 1};
    tbl[7]  = '{0, 4'h0, 0, 1, 0,   1,   1,    1,  4'hE, 1};
    tbl[8]  = '{0, 4'h0, 0, 1, 1,   1,   1,    1,  4'hE, 1};
    tbl[9]  = '{0, 4'h0, 0, 1, 0,   1,   1,    1,  4'hD, 1};
    tbl[10] = '{0, 4'h0, 0, 1, 1,   1,   1,    1,  4'hD, 1};
    tbl[11] = '{0, 4'h0, 0, 1, 0,   1,   1,    1,  4'hC, 1};
    tbl[12] = '{0, 4'h0, 0, 1, 1,   1,   1,    1,  4'hC, 1};
    tbl[13] = '{0, 4'h0, 0, 1, 0,   1,   1,    0,  4'hC, 1};
    tbl[14] = '{0, 4'h0, 0, 1, 1,   1,   0,    0,  4'hC, 1};
    tbl[15] = '{0, 4'h0, 0, 1, 0,   1,   0,    0,  4'hC, 0};

    set_idle();
    do_reset();

    // Full stream F,E,D,C(last) through RUN, DRAIN, DONE
    for (int v = 0; v < 16; v++) begin
      bus.s_valid = tbl[v].sv; bus.s_data = tbl[v].sd; bus.s_last = tbl[v].sl;
      bus.net_ready = tbl[v].nr; bus.net_sample = tbl[v].ns;
      cycle();
      chk($sformatf("tbl%0d_s_ready", v), bus.s_ready, tbl[v].e_sready);
      chk($sformatf("tbl%0d_net_start", v), bus.net_start, tbl[v].e_start);
      chk($sformatf("tbl%0d_nsr", v), bus.net_sample_ready, tbl[v].e_nsr);
      chk($sformatf("tbl%0d_nis", v), bus.net_in_spikes, tbl[v].e_nis);
      chk($sformatf("tbl%0d_busy", v), bus.busy, tbl[v].e_busy);
    end

    // Overfill: fifth entry waits for the first pop; held sample level pops once
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      bus.s_valid = 1; bus.s_data = N_IN'(i); bus.s_last = 0; cycle();
    end
    chk("full_s_ready", bus.s_ready, 0);
    bus.s_data = 4'd5;
    cycle(); cycle();
    chk("full_stall_s_ready", bus.s_ready, 0);
    chk("full_head", bus.net_in_spikes, 1);
    bus.net_ready = 1; cycle(); bus.net_ready = 0;
    chk("start_rise", bus.net_start, 1);
    bus.net_sample = 1;
    cycle(); cycle(); cycle();
    bus.s_valid = 0;
    bus.net_sample = 0; cycle();
    chk("held_sample_one_pop", bus.net_in_spikes, 2);
    for (int i = 3; i <= 5; i++) begin
      pulse_sample();
      chk($sformatf("order_%0d", i), bus.net_in_spikes, N_IN'(i));
    end
    pulse_sample();
    chk("empty_hold_nis", bus.net_in_spikes, 5);
    chk("empty_nsr", bus.net_sample_ready, 0);
    pulse_sample();
    chk("empty_event_nis", bus.net_in_spikes, 5);
    chk("empty_event_busy", bus.busy, 1);
    bus.s_valid = 1; bus.s_data = 4'd6; bus.s_last = 1; cycle();
    bus.s_valid = 0; bus.s_last = 0;
    pulse_sample();
    chk("drain_start", bus.net_start, 1);
    pulse_sample();
    chk("done_idle_busy", bus.busy, 0);

    // Window counting and saturation
    do_reset();
    bus.s_valid = 1; bus.s_data = 4'hA; cycle();
    bus.s_data = 4'hB; bus.s_last = 1; cycle();
    bus.s_valid = 0; bus.s_last = 0;
    bus.net_ready = 1; cycle(); bus.net_ready = 0;
    bus.net_out_spikes = 2'b01;
    repeat (7) cycle();
    bus.net_out_spikes = 2'b00;
    bus.net_sample = 1; cycle();
    chk("cnt7_res_valid", bus.res_valid, CountEn);
    chk("cnt7_res_count", bus.res_count, CountEn ? 16'h0007 : 16'h0000);
    bus.net_sample = 0; cycle();
    chk("cnt7_pulse_end", bus.res_valid, 0);
    bus.net_out_spikes = 2'b11;
    repeat (300) cycle();
    bus.net_out_spikes = 2'b00;
    bus.net_sample = 1; cycle();
    chk("sat_res_count", bus.res_count, CountEn ? 16'hFFFF : 16'h0000);
    bus.net_sample = 0; cycle();
    pulse_sample();
    chk("res_hold", bus.res_valid, 0);

    // Reset in the middle of a run with two entries still queued
    do_reset();
    for (int i = 7; i <= 9; i++) begin
      bus.s_valid = 1; bus.s_data = N_IN'(i); bus.s_last = (i == 9); cycle();
    end
    bus.s_valid = 0; bus.s_last = 0;
    bus.net_ready = 1; cycle(); bus.net_ready = 0;
    bus.net_out_spikes = 2'b01;
    pulse_sample();
    chk("pre_abort_head", bus.net_in_spikes, 8);
    rst_n = 0;
    #2;
    check_reset_outputs("abort");
    set_idle();
    model_reset();
    @(posedge clk); #1;
    chk("abort_no_res_valid", bus.res_valid, 0);
    rst_n = 1;
    cycle();
    chk("abort_s_ready", bus.s_ready, 1);
    chk("abort_fifo_empty", bus.net_sample_ready, 0);
    chk("abort_nis", bus.net_in_spikes, 0);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 800; c++) begin
      bus.s_valid = ($urandom_range(0, 1) == 1);
      bus.s_data = N_IN'($urandom);
      bus.s_last = ($urandom_range(0, 3) == 0);
      bus.net_ready = ($urandom_range(0, 1) == 1);
      bus.net_sample = ($urandom_range(0, 2) == 0);
      bus.net_out_spikes = N_OUT'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
